// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   md_op_e    : decoded multiply/divide op codes driven on Op
//   md_state_e : controller states of hilo_muldiv_unit
//   DIV0_QUOT  : quotient written to LO on divide by zero
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MSUB  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // MADD/MSUB accumulate a signed product.
  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and hilo_muldiv_unit.
//   master (EX side)  : drives Start, Op, A, B, Flush
//   slave  (the unit) : drives Busy, Stall, Done, HI, LO
interface hilo_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Stall, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Stall, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply / restoring divide datapath.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture op_a (multiplier/dividend) and op_b (multiplicand/divisor), clear counter
//   step     : perform ITER_PER_CYCLE radix-2 steps
//   is_div   : select divide steps instead of multiply steps
//   acc      : multiply -> 64-bit product; divide -> {remainder, quotient}
//   last     : counter is at its terminal value (final step cycle)
module muldiv_core
  import mips_pkg::*;
#(
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [63:0] acc,
  output logic        last
);

  localparam int unsigned TERM = 32 / ITER_PER_CYCLE;

  logic [63:0] acc_q, acc_d;
  logic [31:0] dsor_q, dsor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_v;
  logic [32:0] sum_v;

  // One accumulator serves both ops: for multiply the upper half collects
  // partial sums while the multiplier shifts out of the lower half; for
  // divide the upper half is the partial remainder and quotient bits shift
  // into the lower half as dividend bits leave it.
  always_comb begin
    acc_d  = acc_q;
    dsor_d = dsor_q;
    cnt_d  = cnt_q;
    acc_v  = acc_q;
    sum_v  = '0;
    if (load) begin
      acc_d  = {32'd0, op_a};
      dsor_d = op_b;
      cnt_d  = '0;
    end else if (step) begin
      for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
        if (is_div) begin
          sum_v = acc_v[63:31];
          if (sum_v >= {1'b0, dsor_q}) begin
            sum_v = sum_v - {1'b0, dsor_q};
            acc_v = {sum_v[31:0], acc_v[30:0], 1'b1};
          end else begin
            acc_v = {sum_v[31:0], acc_v[30:0], 1'b0};
          end
        end else begin
          sum_v = {1'b0, acc_v[63:32]} + (acc_v[0] ? {1'b0, dsor_q} : 33'd0);
          acc_v = {sum_v, acc_v[31:1]};
        end
      end
      acc_d = acc_v;
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == 6'(TERM - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//   Clk, Rst : clock, asynchronous active-high reset
//   bus      : slave side of hilo_muldiv_unit_if
//              Start/Op/A/B request, Flush abort,
//              Busy (op in flight), Stall (hold upstream), Done (HI/LO commit pulse),
//              HI/LO architectural registers
// MTHI/MTLO write in one cycle; other ops run IDLE->PREP->CALC->FIX->DONE.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned ITER_PER_CYCLE = 1,
  parameter int unsigned XLEN           = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  hilo_muldiv_unit_if.slave  bus
);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic [2*XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic [63:0] core_acc;
  logic        core_last;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  muldiv_core #(
    .ITER_PER_CYCLE(ITER_PER_CYCLE)
  ) u_core (
    .clk    (Clk),
    .rst    (Rst),
    .load   (state_q == ST_PREP),
    .step   (state_q == ST_CALC),
    .is_div (op_is_div(op_q)),
    .op_a   (op_is_signed(op_q) ? abs32(a_q) : a_q),
    .op_b   (op_is_signed(op_q) ? abs32(b_q) : b_q),
    .acc    (core_acc),
    .last   (core_last)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    res_d     = res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    prod_s = neg_res_q ? (64'd0 - core_acc) : core_acc;
    quo_s  = neg_res_q ? (32'd0 - core_acc[31:0]) : core_acc[31:0];
    rem_s  = neg_rem_q ? (32'd0 - core_acc[63:32]) : core_acc[63:32];

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.Op == MD_MTHI) begin
            hi_d = bus.A;
          end else if (bus.Op == MD_MTLO) begin
            lo_d = bus.A;
          end else begin
            op_d    = md_op_e'(bus.Op);
            a_d     = bus.A;
            b_d     = bus.B;
            state_d = ST_PREP;
          end
        end
      end
      ST_PREP: begin
        neg_res_d = op_is_signed(op_q) & (a_q[31] ^ b_q[31]);
        neg_rem_d = op_is_signed(op_q) & a_q[31];
        div0_d    = op_is_div(op_q) && (b_q == '0);
        state_d   = (op_is_div(op_q) && (b_q == '0)) ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_is_div(op_q)) begin
          res_d = div0_q ? {a_q, DIV0_QUOT} : {rem_s, quo_s};
        end else if (op_q == MD_MADD) begin
          res_d = {hi_q, lo_q} + prod_s;
        end else if (op_q == MD_MSUB) begin
          res_d = {hi_q, lo_q} - prod_s;
        end else begin
          res_d = prod_s;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        {hi_d, lo_d} = res_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything: drops any launch or commit this cycle.
    if (bus.Flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      res_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.Busy  = (state_q != ST_IDLE);
  assign bus.Stall = (state_q != ST_IDLE) | (bus.Start & (bus.Op < 3'd6));
  // Done marks the cycle whose closing edge commits HI/LO.
  assign bus.Done  = ~bus.Flush &
                     ((state_q == ST_DONE) |
                      ((state_q == ST_IDLE) & bus.Start & (bus.Op >= 3'd6)));
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: dut1 runs one step per cycle, dut2 two.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_muldiv_unit_if bus1();
  hilo_muldiv_unit_if bus2();

  hilo_muldiv_unit #(.ITER_PER_CYCLE(1), .XLEN(32)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));
  hilo_muldiv_unit #(.ITER_PER_CYCLE(2), .XLEN(32)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2));

  always #5 Clk = ~Clk;

  // The EX controller never issues while the unit is busy.
  always @(posedge Clk) begin
    if (!Rst) begin
      assert (!(bus1.Start && bus1.Busy)) else $error("dut1: Start issued while Busy");
      assert (!(bus2.Start && bus2.Busy)) else $error("dut2: Start issued while Busy");
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic flush);
    if (sel) begin
      bus2.Start = 1'b1; bus2.Op = op; bus2.A = a; bus2.B = b; bus2.Flush = flush;
    end else begin
      bus1.Start = 1'b1; bus1.Op = op; bus1.A = a; bus1.B = b; bus1.Flush = flush;
    end
  endtask

  task automatic idle_inputs();
    bus1.Start = 1'b0; bus1.Flush = 1'b0;
    bus2.Start = 1'b0; bus2.Flush = 1'b0;
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? bus2.Busy : bus1.Busy;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bus2.Done : bus1.Done;
  endfunction

  function automatic logic [63:0] hilo_of(input bit sel);
    return sel ? {bus2.HI, bus2.LO} : {bus1.HI, bus1.LO};
  endfunction

  // Issues in cycle 0, returns the Done cycle (-1 on timeout), the number of
  // Busy cycles seen, cycle-0 Busy/Stall, and HI/LO the cycle after Done.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int done_cyc, output int busy_cnt,
                        output logic busy0, output logic stall0, output logic [63:0] hilo);
    issue(sel, op, a, b, 1'b0);
    #1;
    busy0  = busy_of(sel);
    stall0 = sel ? bus2.Stall : bus1.Stall;
    done_cyc = -1;
    busy_cnt = 0;
    tick();
    idle_inputs();
    for (int c = 1; c <= 100; c++) begin
      if (busy_of(sel)) busy_cnt++;
      if (done_of(sel)) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    tick();
    hilo = hilo_of(sel);
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    issue(1'b0, op, a, 32'd0, 1'b0);
    #1;
    check_eq("mt_done", {63'd0, bus1.Done}, 64'd1);
    check_eq("mt_nostall", {62'd0, bus1.Busy, bus1.Stall}, 64'd0);
    tick();
    idle_inputs();
  endtask

  initial begin
    int          dc, bc;
    logic        b0, s0, saw_done;
    logic [63:0] hl;

    Rst = 1'b1;
    bus1.Op = '0; bus1.A = '0; bus1.B = '0;
    bus2.Op = '0; bus2.A = '0; bus2.B = '0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_hilo1", hilo_of(1'b0), 64'd0);
    check_eq("rst_flags1", {62'd0, bus1.Busy, bus1.Done}, 64'd0);
    check_eq("rst_hilo2", hilo_of(1'b1), 64'd0);
    Rst = 1'b0;
    tick();

    // MULT -3 * 7
    run_op(1'b0, MD_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc, b0, s0, hl);
    check_eq("mult_busy0", {63'd0, b0}, 64'd0);
    check_eq("mult_stall0", {63'd0, s0}, 64'd1);
    check_eq("mult_done_cyc", 64'(dc), 64'd35);
    check_eq("mult_busy_cycles", 64'(bc), 64'd35);
    check_eq("mult_hilo", hl, 64'hFFFF_FFFF_FFFF_FFEB);
    check_eq("mult_busy_after", {63'd0, bus1.Busy}, 64'd0);

    run_op(1'b0, MD_DIVU, 32'd100, 32'd7, dc, bc, b0, s0, hl);
    check_eq("divu_hilo", hl, 64'h0000_0002_0000_000E);

    run_op(1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2, dc, bc, b0, s0, hl);
    check_eq("div_neg_hilo", hl, 64'hFFFF_FFFF_FFFF_FFFD);

    move_to(MD_MTLO, 32'd5);
    move_to(MD_MTHI, 32'd0);
    check_eq("mt_hilo", hilo_of(1'b0), 64'h0000_0000_0000_0005);
    run_op(1'b0, MD_MADD, 32'd2, 32'd3, dc, bc, b0, s0, hl);
    check_eq("madd_hilo", hl, 64'h0000_0000_0000_000B);
    run_op(1'b0, MD_MSUB, 32'd4, 32'd4, dc, bc, b0, s0, hl);
    check_eq("msub_hilo", hl, 64'hFFFF_FFFF_FFFF_FFFB);

    // Divide by zero skips CALC: PREP(1) FIX(2) DONE(3)
    run_op(1'b0, MD_DIV, 32'h0000_1234, 32'd0, dc, bc, b0, s0, hl);
    check_eq("div0_hilo", hl, 64'h0000_1234_FFFF_FFFF);
    check_eq("div0_done_cyc", 64'(dc), 64'd3);

    run_op(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc, b0, s0, hl);
    check_eq("div_ovf_hilo", hl, 64'h0000_0000_8000_0000);

    // MULTU flushed at cycle 10
    issue(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      idle_inputs();
      saw_done |= bus1.Done;
    end
    bus1.Flush = 1'b1;
    #1;
    check_eq("flush_busy_c10", {63'd0, bus1.Busy}, 64'd1);
    saw_done |= bus1.Done;
    tick();
    bus1.Flush = 1'b0;
    check_eq("flush_busy_c11", {63'd0, bus1.Busy}, 64'd0);
    for (int c = 0; c < 40; c++) begin
      saw_done |= bus1.Done;
      tick();
    end
    check_eq("flush_no_done", {63'd0, saw_done}, 64'd0);
    check_eq("flush_hilo", hilo_of(1'b0), 64'h0000_0000_8000_0000);

    // Flush with Start in IDLE: nothing launches or commits
    issue(1'b0, MD_MTLO, 32'h0000_DEAD, 32'd0, 1'b1);
    #1;
    check_eq("flush_mt_done", {63'd0, bus1.Done}, 64'd0);
    tick();
    idle_inputs();
    check_eq("flush_mt_hilo", hilo_of(1'b0), 64'h0000_0000_8000_0000);
    issue(1'b0, MD_MULT, 32'd3, 32'd3, 1'b1);
    tick();
    idle_inputs();
    check_eq("flush_start_busy", {63'd0, bus1.Busy}, 64'd0);

    // Asynchronous reset between edges during CALC
    issue(1'b0, MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      idle_inputs();
    end
    check_eq("pre_rst_busy", {63'd0, bus1.Busy}, 64'd1);
    #3;
    Rst = 1'b1;
    #1;
    check_eq("async_rst_flags", {62'd0, bus1.Busy, bus1.Done}, 64'd0);
    check_eq("async_rst_hilo", hilo_of(1'b0), 64'd0);
    tick();
    Rst = 1'b0;
    tick();

    // Two steps per cycle
    run_op(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc, b0, s0, hl);
    check_eq("ipc2_done_cyc", 64'(dc), 64'd19);
    check_eq("ipc2_busy_cycles", 64'(bc), 64'd19);
    check_eq("ipc2_hilo", hl, 64'hFFFF_FFFF_FFFF_FFEB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
